// File: rtl/lcv_mul32_seq.sv
// 32x32->64 multiply sequenced over one registered 17x17 signed multiplier.
// Optional: define LCV_MUL32_SEQ_EARLY_ZERO_EN to skip the multiplier for zero operands.
module lcv_mul32_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        inp_valid,
  output logic        inp_ready,
  input  logic [31:0] inp_a,
  input  logic [31:0] inp_b,
  input  logic        inp_signed,
  output logic        outp_valid,
  input  logic        outp_ready,
  output logic [63:0] outp_prod,
  output logic        outp_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_LAST,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic        [31:0] r_a;
  logic        [31:0] r_b;
  logic               r_sgn;
  logic        [1:0]  r_idx;
  logic        [63:0] r_acc;
  logic signed [33:0] r_prod;

  logic               w_latch;
  logic               w_acc_clr;
  logic               w_acc_en;
  logic               w_mul_en;
  logic               w_idx_clr;
  logic               w_idx_inc;
  logic               w_zero_op;

  logic signed [16:0] w_ah;
  logic signed [16:0] w_al;
  logic signed [16:0] w_bh;
  logic signed [16:0] w_bl;
  logic signed [16:0] w_mx;
  logic signed [16:0] w_my;
  logic signed [33:0] w_mp;
  logic        [1:0]  w_pp_idx;
  logic        [5:0]  w_shift;
  logic        [63:0] w_pp_ext;
  logic        [63:0] w_pp_sh;

  // Low halves are magnitude bits; only the high halves carry sign.
  assign w_ah = {r_sgn & r_a[31], r_a[31:16]};
  assign w_al = {1'b0, r_a[15:0]};
  assign w_bh = {r_sgn & r_b[31], r_b[31:16]};
  assign w_bl = {1'b0, r_b[15:0]};

  // idx[1] picks the a half, idx[0] the b half.
  assign w_mx = r_idx[1] ? w_ah : w_al;
  assign w_my = r_idx[0] ? w_bh : w_bl;
  assign w_mp = w_mx * w_my;

  // r_prod always holds the product issued one cycle earlier.
  assign w_pp_idx = (r_state == S_LAST) ? 2'd3 : (r_idx - 2'd1);

  always_comb begin
    w_shift = 6'd0;
    unique case (w_pp_idx)
      2'd0:    w_shift = 6'd0;
      2'd1:    w_shift = 6'd16;
      2'd2:    w_shift = 6'd16;
      default: w_shift = 6'd32;
    endcase
  end

  assign w_pp_ext = {{30{r_prod[33]}}, r_prod};
  assign w_pp_sh  = w_pp_ext << w_shift;

`ifdef LCV_MUL32_SEQ_EARLY_ZERO_EN
  assign w_zero_op = (inp_a == 32'd0) || (inp_b == 32'd0);
`else
  assign w_zero_op = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_acc_clr   = 1'b0;
    w_acc_en    = 1'b0;
    w_mul_en    = 1'b0;
    w_idx_clr   = 1'b0;
    w_idx_inc   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (inp_valid) begin
          w_latch   = 1'b1;
          w_acc_clr = 1'b1;
          w_idx_clr = 1'b1;
          if (w_zero_op) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        w_mul_en  = 1'b1;
        w_acc_en  = (r_idx != 2'd0);
        w_idx_inc = 1'b1;
        if (r_idx == 2'd3) begin
          w_state_nxt = S_LAST;
        end
      end
      S_LAST: begin
        w_acc_en    = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (outp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= 32'd0;
      r_b   <= 32'd0;
      r_sgn <= 1'b0;
    end else if (w_latch) begin
      r_a   <= inp_a;
      r_b   <= inp_b;
      r_sgn <= inp_signed;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= 2'd0;
    end else if (w_idx_clr) begin
      r_idx <= 2'd0;
    end else if (w_idx_inc) begin
      r_idx <= r_idx + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod <= '0;
    end else if (w_mul_en) begin
      r_prod <= w_mp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= 64'd0;
    end else if (w_acc_clr) begin
      r_acc <= 64'd0;
    end else if (w_acc_en) begin
      r_acc <= r_acc + w_pp_sh;
    end
  end

  assign inp_ready  = (r_state == S_IDLE) && !rst;
  assign outp_valid = (r_state == S_DONE);
  assign outp_busy  = (r_state != S_IDLE);
  assign outp_prod  = r_acc;

endmodule

// File: tb/tb_lcv_mul32_seq.sv
// Directed and randomised checks for lcv_mul32_seq.
// Latency is counted in edges including the accept edge.
module tb_lcv_mul32_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inp_valid = 1'b0;
  logic        inp_ready;
  logic [31:0] inp_a = 32'd0;
  logic [31:0] inp_b = 32'd0;
  logic        inp_signed = 1'b0;
  logic        outp_valid;
  logic        outp_ready = 1'b1;
  logic [63:0] outp_prod;
  logic        outp_busy;

  int n_vec = 0;
  int n_err = 0;

`ifdef LCV_MUL32_SEQ_EARLY_ZERO_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 6;
`endif

  always #5 clk = ~clk;

  lcv_mul32_seq dut (
    .clk        (clk),
    .rst        (rst),
    .inp_valid  (inp_valid),
    .inp_ready  (inp_ready),
    .inp_a      (inp_a),
    .inp_b      (inp_b),
    .inp_signed (inp_signed),
    .outp_valid (outp_valid),
    .outp_ready (outp_ready),
    .outp_prod  (outp_prod),
    .outp_busy  (outp_busy)
  );

  function automatic logic [63:0] ref_mul(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic s);
    logic [63:0] x;
    logic [63:0] y;
    x = s ? {{32{a[31]}}, a} : {32'd0, a};
    y = s ? {{32{b[31]}}, b} : {32'd0, b};
    return x * y;
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic s, input bit rnd,
                        output logic [63:0] p, output int lat);
    int w;
    w = 0;
    while (!inp_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    inp_a = a; inp_b = b; inp_signed = s; inp_valid = 1'b1;
    @(posedge clk); #1;
    inp_valid = 1'b0;
    lat = 1;
    while (!outp_valid && lat < 30) begin
      if (rnd) outp_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1; lat++;
    end
    p = outp_prod;
    if (!outp_valid) begin
      n_vec++; n_err++;
      $display("FAIL op_timeout a=%h b=%h got valid=0 need valid=1", a, b);
      return;
    end
    w = 0;
    while (w < 30) begin
      if (outp_ready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1; w++;
      n_vec++;
      if (outp_valid !== 1'b1 || outp_prod !== p) begin
        n_err++;
        $display("FAIL hold_stable got v=%b p=%h need v=1 p=%h",
                 outp_valid, outp_prod, p);
      end
      outp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    outp_ready = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    n_vec++;
    if (outp_valid !== 1'b0 || outp_prod !== 64'd0 || outp_busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out got v=%b p=%h b=%b need 0/0/0",
               outp_valid, outp_prod, outp_busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_vec++;
    if (inp_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready got %b need 1", inp_ready);
    end
  endtask

  task automatic test_unsigned();
    logic [63:0] p;
    int lat;
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, p, lat);
    n_vec++;
    if (p !== 64'hFFFFFFFE00000001) begin
      n_err++;
      $display("FAIL unsigned_max got %h need %h", p, 64'hFFFFFFFE00000001);
    end
    n_vec++;
    if (lat !== 6) begin
      n_err++;
      $display("FAIL unsigned_latency got %0d need 6", lat);
    end
    run_op(32'h00012345, 32'h00010000, 1'b0, 1'b0, p, lat);
    n_vec++;
    if (p !== 64'h0000000123450000) begin
      n_err++;
      $display("FAIL unsigned_shift got %h need %h", p, 64'h0000000123450000);
    end
  endtask

  task automatic test_signed();
    logic [63:0] p;
    int lat;
    run_op(32'h80000000, 32'h80000000, 1'b1, 1'b0, p, lat);
    n_vec++;
    if (p !== 64'h4000000000000000) begin
      n_err++;
      $display("FAIL signed_minmin got %h need %h", p, 64'h4000000000000000);
    end
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, p, lat);
    n_vec++;
    if (p !== 64'hFFFFFFFFFFFFFFFF) begin
      n_err++;
      $display("FAIL signed_neg1 got %h need %h", p, 64'hFFFFFFFFFFFFFFFF);
    end
    run_op(32'h00000003, 32'hFFFFFFFB, 1'b1, 1'b0, p, lat);
    n_vec++;
    if (p !== 64'hFFFFFFFFFFFFFFF1) begin
      n_err++;
      $display("FAIL signed_3xm5 got %h need %h", p, 64'hFFFFFFFFFFFFFFF1);
    end
    run_op(32'h80000000, 32'h80000000, 1'b0, 1'b0, p, lat);
    n_vec++;
    if (p !== 64'h4000000000000000) begin
      n_err++;
      $display("FAIL unsigned_hibit got %h need %h", p, 64'h4000000000000000);
    end
  endtask

  task automatic test_hold();
    int w;
    outp_ready = 1'b0;
    inp_a = 32'h00010000; inp_b = 32'h00010000; inp_signed = 1'b0;
    inp_valid = 1'b1;
    @(posedge clk); #1;
    inp_valid = 1'b0;
    w = 0;
    while (!outp_valid && w < 30) begin
      @(posedge clk); #1; w++;
    end
    inp_a = 32'd7; inp_b = 32'd6; inp_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (outp_valid !== 1'b1 || outp_prod !== 64'h0000000100000000 ||
          inp_ready !== 1'b0) begin
        n_err++;
        $display("FAIL hold_cycle%0d got v=%b p=%h r=%b need v=1 p=%h r=0",
                 i, outp_valid, outp_prod, inp_ready, 64'h0000000100000000);
      end
    end
    outp_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (outp_busy !== 1'b0 || inp_ready !== 1'b1) begin
      n_err++;
      $display("FAIL hold_release got busy=%b rdy=%b need 0/1",
               outp_busy, inp_ready);
    end
    @(posedge clk); #1;
    inp_valid = 1'b0;
    n_vec++;
    if (outp_busy !== 1'b1) begin
      n_err++;
      $display("FAIL hold_next_accept got busy=%b need 1", outp_busy);
    end
    w = 0;
    while (!outp_valid && w < 30) begin
      @(posedge clk); #1; w++;
    end
    n_vec++;
    if (outp_valid !== 1'b1 || outp_prod !== 64'd42) begin
      n_err++;
      $display("FAIL hold_next_prod got v=%b p=%h need v=1 p=%h",
               outp_valid, outp_prod, 64'd42);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [63:0] p;
    int lat;
    inp_a = 32'h12345678; inp_b = 32'd9; inp_signed = 1'b0;
    inp_valid = 1'b1;
    @(posedge clk); #1;
    inp_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_vec++;
    if (outp_busy !== 1'b1) begin
      n_err++;
      $display("FAIL mid_busy got %b need 1", outp_busy);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (outp_valid !== 1'b0 || outp_prod !== 64'd0 || outp_busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset got v=%b p=%h b=%b need 0/0/0",
               outp_valid, outp_prod, outp_busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    run_op(32'd3, 32'd5, 1'b0, 1'b0, p, lat);
    n_vec++;
    if (p !== 64'd15 || lat !== 6) begin
      n_err++;
      $display("FAIL mid_recover got p=%h lat=%0d need p=%h lat=6",
               p, lat, 64'd15);
    end
  endtask

  task automatic test_zero();
    logic [63:0] p;
    int lat;
    run_op(32'd0, 32'h12345678, 1'b0, 1'b0, p, lat);
    n_vec++;
    if (p !== 64'd0 || lat !== ZLAT) begin
      n_err++;
      $display("FAIL zero_a got p=%h lat=%0d need p=0 lat=%0d", p, lat, ZLAT);
    end
    run_op(32'hDEADBEEF, 32'd0, 1'b1, 1'b0, p, lat);
    n_vec++;
    if (p !== 64'd0 || lat !== ZLAT) begin
      n_err++;
      $display("FAIL zero_b got p=%h lat=%0d need p=0 lat=%0d", p, lat, ZLAT);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] p;
    logic [63:0] e;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    int lat;
    for (int i = 0; i < 24; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      if (i == 0) begin a = 32'h7FFFFFFF; b = 32'h80000000; s = 1'b1; end
      if (i == 1) begin a = 32'h0000FFFF; b = 32'hFFFF0000; s = 1'b1; end
      e = ref_mul(a, b, s);
      run_op(a, b, s, 1'b1, p, lat);
      n_vec++;
      if (p !== e) begin
        n_err++;
        $display("FAIL b2b_%0d a=%h b=%h s=%b got %h need %h",
                 i, a, b, s, p, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_hold();
    test_reset_mid();
    test_zero();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
